// File: rtl/multicycle_ctrl_pkg.sv
// Shared types for the multicycle MIPS main control: state encoding, opcodes
// and the datapath control bundle.
package multicycle_ctrl_pkg;

   typedef enum logic [3:0] {
      StFetch  = 4'd0,
      StDecode = 4'd1,
      StMemAdr = 4'd2,
      StMemRd  = 4'd3,
      StMemWb  = 4'd4,
      StMemWr  = 4'd5,
      StRtExe  = 4'd6,
      StRtWb   = 4'd7,
      StBranch = 4'd8,
      StJump   = 4'd9,
      StAddiEx = 4'd10,
      StAddiWb = 4'd11
   } ctrl_state_e;

   localparam logic [5:0] OpRtype = 6'b000000;
   localparam logic [5:0] OpLw    = 6'b100011;
   localparam logic [5:0] OpSw    = 6'b101011;
   localparam logic [5:0] OpBeq   = 6'b000100;
   localparam logic [5:0] OpJ     = 6'b000010;
   localparam logic [5:0] OpAddi  = 6'b001000;

   typedef struct packed {
      logic       pcwrite;
      logic       pcwritecond;
      logic       iord;
      logic       memread;
      logic       memwrite;
      logic       irwrite;
      logic       memtoreg;
      logic       regdst;
      logic       regwrite;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic       aluop1;
      logic       aluop0;
      logic [1:0] pcsource;
      logic       instr_done;
   } ctrl_out_t;

   function automatic logic is_legal_op(logic [5:0] op);
      return (op == OpRtype) || (op == OpLw) || (op == OpSw) ||
             (op == OpBeq) || (op == OpJ) || (op == OpAddi);
   endfunction

endpackage

// File: rtl/multicycle_ctrl_outdec.sv
// Combinational decode of the current control state (and memory handshake)
// into the datapath control bundle.
module multicycle_ctrl_outdec
   import multicycle_ctrl_pkg::*;
(
   input  ctrl_state_e state,
   input  logic        mem_ready,
   output ctrl_out_t   ctrl
);

   always_comb begin
      ctrl = '0;
      case (state)
         StFetch: begin
            ctrl.memread = 1'b1;
            ctrl.alusrcb = 2'b01;
            // PC+4 and IR load commit only when the fetch actually completes
            ctrl.irwrite = mem_ready;
            ctrl.pcwrite = mem_ready;
         end
         StDecode: ctrl.alusrcb = 2'b11;
         StMemAdr: begin
            ctrl.alusrca = 1'b1;
            ctrl.alusrcb = 2'b10;
         end
         StMemRd: begin
            ctrl.memread = 1'b1;
            ctrl.iord    = 1'b1;
         end
         StMemWb: begin
            ctrl.regwrite   = 1'b1;
            ctrl.memtoreg   = 1'b1;
            ctrl.instr_done = 1'b1;
         end
         StMemWr: begin
            ctrl.memwrite   = 1'b1;
            ctrl.iord       = 1'b1;
            ctrl.instr_done = mem_ready;
         end
         StRtExe: begin
            ctrl.alusrca = 1'b1;
            ctrl.aluop1  = 1'b1;
         end
         StRtWb: begin
            ctrl.regwrite   = 1'b1;
            ctrl.regdst     = 1'b1;
            ctrl.instr_done = 1'b1;
         end
         StBranch: begin
            ctrl.alusrca     = 1'b1;
            ctrl.aluop0      = 1'b1;
            ctrl.pcwritecond = 1'b1;
            ctrl.pcsource    = 2'b01;
            ctrl.instr_done  = 1'b1;
         end
         StJump: begin
            ctrl.pcwrite    = 1'b1;
            ctrl.pcsource   = 2'b10;
            ctrl.instr_done = 1'b1;
         end
         StAddiEx: begin
            ctrl.alusrca = 1'b1;
            ctrl.alusrcb = 2'b10;
         end
         StAddiWb: begin
            ctrl.regwrite   = 1'b1;
            ctrl.instr_done = 1'b1;
         end
         default: ctrl = '0;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS main control FSM: state register, next-state logic and
// reset gating of the write/request strobes.
module multicycle_ctrl
   import multicycle_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] op,
   input  logic       mem_ready,
   output logic       pcwrite,
   output logic       pcwritecond,
   output logic       iord,
   output logic       memread,
   output logic       memwrite,
   output logic       irwrite,
   output logic       memtoreg,
   output logic       regdst,
   output logic       regwrite,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic       aluop1,
   output logic       aluop0,
   output logic [1:0] pcsource,
   output logic       instr_done,
   output logic       illegal_op,
   output logic [3:0] state
);

   ctrl_state_e state_q, state_d;
   ctrl_out_t   ctrl;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= StFetch;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = StFetch;
      case (state_q)
         StFetch:  state_d = mem_ready ? StDecode : StFetch;
         StDecode: begin
            case (op)
               OpLw, OpSw: state_d = StMemAdr;
               OpRtype:    state_d = StRtExe;
               OpBeq:      state_d = StBranch;
               OpJ:        state_d = StJump;
               OpAddi:     state_d = StAddiEx;
               default:    state_d = StFetch;
            endcase
         end
         StMemAdr: state_d = (op == OpLw) ? StMemRd : StMemWr;
         StMemRd:  state_d = mem_ready ? StMemWb : StMemRd;
         StMemWr:  state_d = mem_ready ? StFetch : StMemWr;
         StRtExe:  state_d = StRtWb;
         StAddiEx: state_d = StAddiWb;
         default:  state_d = StFetch;
      endcase
   end

   multicycle_ctrl_outdec u_outdec (
      .state     (state_q),
      .mem_ready (mem_ready),
      .ctrl      (ctrl)
   );

   // Reset asynchronously forces FETCH, whose decode would otherwise raise
   // memread; the strobes are masked so nothing fires while rst_n is low.
   assign pcwrite     = ctrl.pcwrite & rst_n;
   assign pcwritecond = ctrl.pcwritecond & rst_n;
   assign irwrite     = ctrl.irwrite & rst_n;
   assign memread     = ctrl.memread & rst_n;
   assign memwrite    = ctrl.memwrite & rst_n;
   assign regwrite    = ctrl.regwrite & rst_n;
   assign instr_done  = ctrl.instr_done & rst_n;
   assign illegal_op  = rst_n & (state_q == StDecode) & ~is_legal_op(op);

   assign iord     = ctrl.iord;
   assign memtoreg = ctrl.memtoreg;
   assign regdst   = ctrl.regdst;
   assign alusrca  = ctrl.alusrca;
   assign alusrcb  = ctrl.alusrcb;
   assign aluop1   = ctrl.aluop1;
   assign aluop0   = ctrl.aluop0;
   assign pcsource = ctrl.pcsource;
   assign state    = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class cycle by
// cycle against hand-written expected state and control vectors.
module tb_multicycle_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] op;
   logic       mem_ready;
   logic       pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
   logic       memtoreg, regdst, regwrite, alusrca, aluop1, aluop0;
   logic       instr_done, illegal_op;
   logic [1:0] alusrcb, pcsource;
   logic [3:0] state;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   multicycle_ctrl dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .op          (op),
      .mem_ready   (mem_ready),
      .pcwrite     (pcwrite),
      .pcwritecond (pcwritecond),
      .iord        (iord),
      .memread     (memread),
      .memwrite    (memwrite),
      .irwrite     (irwrite),
      .memtoreg    (memtoreg),
      .regdst      (regdst),
      .regwrite    (regwrite),
      .alusrca     (alusrca),
      .alusrcb     (alusrcb),
      .aluop1      (aluop1),
      .aluop0      (aluop0),
      .pcsource    (pcsource),
      .instr_done  (instr_done),
      .illegal_op  (illegal_op),
      .state       (state)
   );

   localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011;
   localparam logic [5:0] BEQ = 6'b000100, J = 6'b000010, ADDI = 6'b001000;
   localparam logic [5:0] BAD = 6'b111111;

   // Field order: pcwrite pcwritecond iord memread memwrite irwrite memtoreg
   // regdst regwrite alusrca alusrcb[2] aluop[2] pcsource[2] instr_done illegal_op
   function automatic logic [17:0] ov(logic pcw, logic pcwc, logic io, logic mr, logic mw,
                                      logic irw, logic mtr, logic rd, logic rw, logic asa,
                                      logic [1:0] asb, logic [1:0] aop, logic [1:0] pcs,
                                      logic done, logic ill);
      return {pcw, pcwc, io, mr, mw, irw, mtr, rd, rw, asa, asb, aop, pcs, done, ill};
   endfunction

   logic [17:0] e_rst, e_fetch_rdy, e_fetch_wait, e_decode, e_decode_bad, e_memadr, e_memrd;
   logic [17:0] e_memwb, e_memwr_wait, e_memwr_rdy, e_rtexe, e_rtwb, e_branch, e_jump;
   logic [17:0] e_addiex, e_addiwb;

   function automatic logic [17:0] observed();
      return {pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg, regdst,
              regwrite, alusrca, alusrcb, aluop1, aluop0, pcsource, instr_done, illegal_op};
   endfunction

   task automatic check(input string tag, input logic [3:0] exp_state,
                        input logic [17:0] exp_out);
      vectors++;
      assert (state === exp_state) else begin
         miscompares++;
         $error("FAIL %s state: observed %0d expected %0d", tag, state, exp_state);
      end
      vectors++;
      assert (observed() === exp_out) else begin
         miscompares++;
         $error("FAIL %s outputs: observed %b expected %b", tag, observed(), exp_out);
      end
   endtask

   // Apply inputs, check the settled outputs, then advance one clock.
   task automatic cyc(input string tag, input logic [5:0] o, input logic rdy,
                      input logic [3:0] exp_state, input logic [17:0] exp_out);
      op = o;
      mem_ready = rdy;
      #1;
      check(tag, exp_state, exp_out);
      @(posedge clk);
      #1;
   endtask

   initial begin
      e_rst        = ov(0,0,0,0,0,0,0,0,0,0,2'b01,2'b00,2'b00,0,0);
      e_fetch_rdy  = ov(1,0,0,1,0,1,0,0,0,0,2'b01,2'b00,2'b00,0,0);
      e_fetch_wait = ov(0,0,0,1,0,0,0,0,0,0,2'b01,2'b00,2'b00,0,0);
      e_decode     = ov(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0,0);
      e_decode_bad = ov(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0,1);
      e_memadr     = ov(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0);
      e_memrd      = ov(0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,0);
      e_memwb      = ov(0,0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,1,0);
      e_memwr_wait = ov(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0,0);
      e_memwr_rdy  = ov(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,1,0);
      e_rtexe      = ov(0,0,0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0,0);
      e_rtwb       = ov(0,0,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00,1,0);
      e_branch     = ov(0,1,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,1,0);
      e_jump       = ov(1,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,1,0);
      e_addiex     = ov(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0);
      e_addiwb     = ov(0,0,0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00,1,0);

      rst_n = 1'b0;
      op = R;
      mem_ready = 1'b1;
      #2;
      check("reset", 4'd0, e_rst);
      @(negedge clk);
      rst_n = 1'b1;

      // R-type, no waits: 0,1,6,7
      cyc("r_fetch", R, 1'b1, 4'd0, e_fetch_rdy);
      cyc("r_decode", R, 1'b1, 4'd1, e_decode);
      cyc("r_exe", R, 1'b1, 4'd6, e_rtexe);
      cyc("r_wb", R, 1'b1, 4'd7, e_rtwb);

      // LW with two wait cycles on fetch and on the data read: 9 cycles
      cyc("lw_fetch_w0", LW, 1'b0, 4'd0, e_fetch_wait);
      cyc("lw_fetch_w1", LW, 1'b0, 4'd0, e_fetch_wait);
      cyc("lw_fetch", LW, 1'b1, 4'd0, e_fetch_rdy);
      cyc("lw_decode", LW, 1'b1, 4'd1, e_decode);
      cyc("lw_memadr", LW, 1'b0, 4'd2, e_memadr);
      cyc("lw_memrd_w0", LW, 1'b0, 4'd3, e_memrd);
      cyc("lw_memrd_w1", LW, 1'b0, 4'd3, e_memrd);
      cyc("lw_memrd", LW, 1'b1, 4'd3, e_memrd);
      cyc("lw_memwb", LW, 1'b0, 4'd4, e_memwb);

      // BEQ: 0,1,8
      cyc("beq_fetch", BEQ, 1'b1, 4'd0, e_fetch_rdy);
      cyc("beq_decode", BEQ, 1'b1, 4'd1, e_decode);
      cyc("beq_branch", BEQ, 1'b0, 4'd8, e_branch);

      // Illegal opcode flagged in DECODE, then straight back to FETCH
      cyc("bad_fetch", BAD, 1'b1, 4'd0, e_fetch_rdy);
      cyc("bad_decode", BAD, 1'b1, 4'd1, e_decode_bad);

      // SW, no waits: 0,1,2,5
      cyc("sw_fetch", SW, 1'b1, 4'd0, e_fetch_rdy);
      cyc("sw_decode", SW, 1'b1, 4'd1, e_decode);
      cyc("sw_memadr", SW, 1'b1, 4'd2, e_memadr);
      cyc("sw_memwr", SW, 1'b1, 4'd5, e_memwr_rdy);

      // ADDI: 0,1,10,11
      cyc("addi_fetch", ADDI, 1'b1, 4'd0, e_fetch_rdy);
      cyc("addi_decode", ADDI, 1'b1, 4'd1, e_decode);
      cyc("addi_ex", ADDI, 1'b1, 4'd10, e_addiex);
      cyc("addi_wb", ADDI, 1'b1, 4'd11, e_addiwb);

      // SW interrupted by reset while the write is pending
      cyc("swr_fetch", SW, 1'b1, 4'd0, e_fetch_rdy);
      cyc("swr_decode", SW, 1'b1, 4'd1, e_decode);
      cyc("swr_memadr", SW, 1'b1, 4'd2, e_memadr);
      cyc("swr_memwr_w", SW, 1'b0, 4'd5, e_memwr_wait);
      op = SW;
      mem_ready = 1'b1;
      rst_n = 1'b0;
      #1;
      check("swr_reset", 4'd0, e_rst);
      @(negedge clk);
      rst_n = 1'b1;
      cyc("swr_after_w", J, 1'b0, 4'd0, e_fetch_wait);

      // Three back-to-back jumps: 9 cycles
      for (int k = 0; k < 3; k++) begin
         cyc($sformatf("j%0d_fetch", k), J, 1'b1, 4'd0, e_fetch_rdy);
         cyc($sformatf("j%0d_decode", k), J, 1'b1, 4'd1, e_decode);
         cyc($sformatf("j%0d_jump", k), J, 1'b1, 4'd9, e_jump);
      end
      cyc("end_fetch", R, 1'b0, 4'd0, e_fetch_wait);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
